// File: rtl/bcd_countdown_9675_pkg.sv
// Shared types and helpers for the BCD down-counter chain.
package bcd_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        DONE     = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_bcd(input logic [3:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_countdown_9675_digit.sv
// One BCD digit of the down-counter; wraps 0 -> 9 and borrows from the next digit up.
module bcd_down_digit
    import bcd_cnt_pkg::*;
#(
    parameter logic [3:0] RST_NIB = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_nib,
    input  logic       dec_in,
    output logic [3:0] digit,
    output logic       borrow_out
);

    logic [3:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = load_nib;
        end else if (dec_in) begin
            digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) digit_q <= RST_NIB;
        else     digit_q <= digit_d;
    end

    assign digit      = digit_q;
    assign borrow_out = dec_in && (digit_q == 4'd0);

endmodule

// File: rtl/bcd_countdown_9675.sv
// BCD countdown timer: loads a start value, decrements per enabled tick, flags completion at zero.
module bcd_countdown_9675
    import bcd_cnt_pkg::*;
#(
    parameter int                        NUM_DIGITS  = 4,
    parameter logic [4*NUM_DIGITS-1:0]   START_VALUE = 16'h9675
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic                      start,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_val,
    output logic [4*NUM_DIGITS-1:0]   Qdata,
    output logic                      busy,
    output logic                      done,
    output logic                      zero,
    output logic                      load_err
);

    localparam int W = 4 * NUM_DIGITS;
    localparam logic [W-1:0] ONE = W'(1);
    localparam logic ZERO_RST = (START_VALUE == '0);

    state_e          state_q, state_d;
    logic            done_q, done_d;
    logic            zero_q, zero_d;
    logic            load_err_q, load_err_d;
    logic [W-1:0]    qdata;
    logic            load_ok;
    logic            dig_load;
    logic [W-1:0]    dig_nib;
    logic            count_en;
    logic [NUM_DIGITS-1:0] dec_in, borrow;
    logic            underflow_unused;

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!is_bcd(load_val[4*i +: 4])) load_ok = 1'b0;
        end
    end

    // Qdata != 0 guard keeps the chain from ever wrapping below 0000.
    assign count_en = (state_q == COUNTING) && ena && !load && (qdata != '0);

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        zero_d     = zero_q;
        dig_load   = 1'b0;
        dig_nib    = load_val;
        if (load) begin
            if (load_ok) begin
                dig_load = 1'b1;
                state_d  = IDLE;
                zero_d   = (load_val == '0);
            end else begin
                load_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (qdata != '0)) state_d = COUNTING;
                end
                COUNTING: begin
                    if (count_en && (qdata == ONE)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        zero_d  = 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        dig_load = 1'b1;
                        dig_nib  = START_VALUE;
                        state_d  = (START_VALUE != '0) ? COUNTING : IDLE;
                        zero_d   = ZERO_RST;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            zero_q     <= ZERO_RST;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            zero_q     <= zero_d;
            load_err_q <= load_err_d;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_first
            assign dec_in[i] = count_en;
        end else begin : g_rest
            assign dec_in[i] = borrow[i-1];
        end
        bcd_down_digit #(
            .RST_NIB(START_VALUE[4*i +: 4])
        ) u_digit (
            .clk       (clk),
            .rst       (rst),
            .load      (dig_load),
            .load_nib  (dig_nib[4*i +: 4]),
            .dec_in    (dec_in[i]),
            .digit     (qdata[4*i +: 4]),
            .borrow_out(borrow[i])
        );
    end

    assign underflow_unused = borrow[NUM_DIGITS-1];

    assign Qdata    = qdata;
    assign busy     = (state_q == COUNTING);
    assign done     = done_q;
    assign zero     = zero_q;
    assign load_err = load_err_q;

endmodule
